// File: rtl/sampler_link_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : sampler_link_pkg
//  Description : Shared definitions for the sampler link: word field
//                positions, packet type codes, payload widths and helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package sampler_link_pkg;

   // Link word layout
   localparam int WORD_BITS        = 28;
   localparam int MARKER_BIT       = 27;
   localparam int TYPE_MSB         = 26;
   localparam int TYPE_LSB         = 24;
   localparam int SLICE_MSB        = 23;

   // Packet layout
   localparam int PKT_TYPE_BITS    = 6;
   localparam int PKT_PAYLOAD_BITS = 48;
   localparam int FIRST_DATA_BITS  = 32;
   localparam int SLOTS_PER_PKT    = 3;

   // Consecutive good packets needed before framing is trusted
   localparam int LOCK_PACKETS     = 4;

   typedef enum logic [5:0] {
      PKT_NOP   = 6'h00,
      PKT_FIRST = 6'h11,
      PKT_NEXT  = 6'h22,
      PKT_IDLE  = 6'h2a,
      PKT_LAST  = 6'h33
   } pkt_type_e;

   typedef enum logic [0:0] {
      ASM_HEAD = 1'b0,
      ASM_BODY = 1'b1
   } asm_state_e;

   // True for the five packet codes the link defines
   function automatic logic is_known_type(input logic [5:0] t);
      return (t == PKT_NOP)  || (t == PKT_FIRST) || (t == PKT_NEXT) ||
             (t == PKT_IDLE) || (t == PKT_LAST);
   endfunction

   // Shared bit counter: number of ones in a 32-bit vector
   function automatic logic [5:0] bit_count(input logic [31:0] v);
      logic [5:0] n;
      n = '0;
      for (int i = 0; i < 32; i++) begin
         n = n + {5'd0, v[i]};
      end
      return n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sample_depacketizer_if.sv
`default_nettype none
// ============================================================================
//  Interface   : sample_depacketizer_if
//  Description : Link word input and decoded record output of the sampler
//                receive path. master = link/host side, slave = depacketizer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sample_depacketizer_if #(
   parameter int CHANNEL   = 16,
   parameter int DATA_BITS = 16
);
   logic [27:0]                  in_data;
   logic                         in_valid;
   logic                         record_valid;
   logic [CHANNEL-1:0]           diff_bitset;
   logic [CHANNEL*DATA_BITS-1:0] data_compressed;
   logic                         keyframe;
   logic                         link_idle;
   logic                         link_locked;
   logic [15:0]                  err_count;

   modport master (
      output in_data, in_valid,
      input  record_valid, diff_bitset, data_compressed, keyframe,
             link_idle, link_locked, err_count
   );

   modport slave (
      input  in_data, in_valid,
      output record_valid, diff_bitset, data_compressed, keyframe,
             link_idle, link_locked, err_count
   );
endinterface
`default_nettype wire

// File: rtl/rx_word_pairer.sv
`default_nettype none
// ============================================================================
//  Module      : rx_word_pairer
//  Description : Pairs high/low link words into 56-bit packets, flags
//                framing errors and tracks framing lock.
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_word_pairer
   import sampler_link_pkg::*;
(
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic [WORD_BITS-1:0]        word_i,
   input  logic                        word_valid_i,
   output logic                        pkt_valid_o,
   output logic [PKT_TYPE_BITS-1:0]    pkt_type_o,
   output logic [PKT_PAYLOAD_BITS-1:0] pkt_payload_o,
   output logic                        framing_err_o,
   output logic                        link_locked_o
);

   logic                  hi_pending_q, hi_pending_d;
   logic [MARKER_BIT-1:0] hi_word_q,    hi_word_d;
   logic [2:0]            good_cnt_q,   good_cnt_d;

   logic                     w_is_low;
   logic                     w_type_ok;
   logic [PKT_TYPE_BITS-1:0] w_type;

   // Pairing decision, framing-error detection and lock count next state
   always_comb begin
      hi_pending_d  = hi_pending_q;
      hi_word_d     = hi_word_q;
      good_cnt_d    = good_cnt_q;
      pkt_valid_o   = 1'b0;
      framing_err_o = 1'b0;
      w_is_low      = word_i[MARKER_BIT];
      w_type        = {hi_word_q[TYPE_MSB:TYPE_LSB], word_i[TYPE_MSB:TYPE_LSB]};
      w_type_ok     = is_known_type(w_type);
      pkt_type_o    = w_type;
      pkt_payload_o = {hi_word_q[SLICE_MSB:0], word_i[SLICE_MSB:0]};

      if (word_valid_i) begin
         if (!w_is_low) begin
            // A newer high word always wins; losing an older one is an error
            framing_err_o = hi_pending_q;
            hi_pending_d  = 1'b1;
            hi_word_d     = word_i[MARKER_BIT-1:0];
         end else if (!hi_pending_q) begin
            framing_err_o = 1'b1;
         end else begin
            hi_pending_d = 1'b0;
            if (w_type_ok) begin
               pkt_valid_o = 1'b1;
            end else begin
               framing_err_o = 1'b1;
            end
         end
      end

      if (framing_err_o) begin
         good_cnt_d = '0;
      end else if (pkt_valid_o && (good_cnt_q != 3'(LOCK_PACKETS))) begin
         good_cnt_d = good_cnt_q + 3'd1;
      end
   end

   // Pending high word and lock counter registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hi_pending_q <= 1'b0;
         hi_word_q    <= '0;
         good_cnt_q   <= '0;
      end else begin
         hi_pending_q <= hi_pending_d;
         hi_word_q    <= hi_word_d;
         good_cnt_q   <= good_cnt_d;
      end
   end

   assign link_locked_o = (good_cnt_q == 3'(LOCK_PACKETS));

endmodule
`default_nettype wire

// File: rtl/sample_depacketizer.sv
`default_nettype none
// ============================================================================
//  Module      : sample_depacketizer
//  Description : Receive end of the sampler link. Reassembles FIRST/NEXT/LAST
//                packet trains into compressed sample records.
//  Revision    : 1.0 - initial release
// ============================================================================
module sample_depacketizer
   import sampler_link_pkg::*;
#(
   parameter int CHANNEL   = 16,
   parameter int DATA_BITS = 16
)(
   input  logic                rx_clock,
   input  logic                rx_clock_rst,
   sample_depacketizer_if.slave link
);

   localparam int VALUE_BITS = CHANNEL * DATA_BITS;

   // Packet stream from the pairer
   logic                        w_pkt_valid;
   logic [PKT_TYPE_BITS-1:0]    w_pkt_type;
   logic [PKT_PAYLOAD_BITS-1:0] w_pkt_payload;
   logic                        w_framing_err;
   logic                        w_link_locked;

   // Assembler state
   asm_state_e          state_q, state_d;
   logic [CHANNEL-1:0]  diff_q,  diff_d;
   logic [VALUE_BITS-1:0] slots_q, slots_d;
   logic [5:0]          rem_q,   rem_d;
   logic [5:0]          ptr_q,   ptr_d;

   // Output registers
   logic                  record_valid_q;
   logic [CHANNEL-1:0]    out_diff_q;
   logic [VALUE_BITS-1:0] out_data_q;
   logic                  keyframe_q;
   logic                  link_idle_q,  link_idle_d;
   logic [15:0]           err_count_q,  err_count_d;

   // Assembler combinational
   logic [CHANNEL-1:0]    w_pkt_diff;
   logic [5:0]            w_pc;
   logic                  w_first_ok;
   logic [VALUE_BITS-1:0] w_first_slots;
   logic [1:0]            w_fill;
   logic                  w_start;
   logic                  w_emit;
   logic                  w_emit_body;
   logic [CHANNEL-1:0]    w_emit_diff;
   logic [VALUE_BITS-1:0] w_emit_data;
   logic                  w_abort_err;
   logic                  w_reject_err;
   logic [1:0]            w_err_inc;
   logic [16:0]           w_err_sum;

   rx_word_pairer u_pairer (
      .clk_i         (rx_clock),
      .rst_i         (rx_clock_rst),
      .word_i        (link.in_data),
      .word_valid_i  (link.in_valid),
      .pkt_valid_o   (w_pkt_valid),
      .pkt_type_o    (w_pkt_type),
      .pkt_payload_o (w_pkt_payload),
      .framing_err_o (w_framing_err),
      .link_locked_o (w_link_locked)
   );

   assign w_pkt_diff    = w_pkt_payload[CHANNEL-1:0];
   assign w_pc          = bit_count(32'(w_pkt_diff));
   assign w_first_ok    = (w_pc > 6'd2);
   assign w_first_slots = {{(VALUE_BITS-FIRST_DATA_BITS){1'b0}},
                           w_pkt_payload[PKT_PAYLOAD_BITS-1:PKT_PAYLOAD_BITS-FIRST_DATA_BITS]};

   // Assembler next state: record start, slot filling and emit decision
   always_comb begin
      state_d      = state_q;
      diff_d       = diff_q;
      slots_d      = slots_q;
      rem_d        = rem_q;
      ptr_d        = ptr_q;
      w_fill       = 2'd0;
      w_start      = 1'b0;
      w_emit       = 1'b0;
      w_emit_body  = 1'b0;
      w_abort_err  = 1'b0;
      w_reject_err = 1'b0;
      w_emit_diff  = diff_q;
      // Single-packet record: only as many values as the diff names survive
      w_emit_data  = w_first_slots;
      if (w_pc < 6'd2) begin
         w_emit_data[DATA_BITS +: DATA_BITS] = '0;
      end
      if (w_pc == 6'd0) begin
         w_emit_data[0 +: DATA_BITS] = '0;
      end

      if (w_pkt_valid) begin
         case (state_q)
            ASM_HEAD: begin
               case (w_pkt_type)
                  PKT_FIRST: w_start = 1'b1;
                  PKT_LAST: begin
                     w_emit      = 1'b1;
                     w_emit_diff = w_pkt_diff;
                  end
                  PKT_NEXT:  w_abort_err = 1'b1;
                  default:   ;
               endcase
            end
            ASM_BODY: begin
               case (w_pkt_type)
                  PKT_FIRST: begin
                     w_abort_err = 1'b1;
                     w_start     = 1'b1;
                  end
                  PKT_NEXT: begin
                     if (rem_q > 6'd3) begin
                        w_fill = 2'd3;
                        rem_d  = rem_q - 6'd3;
                        ptr_d  = ptr_q + 6'd3;
                     end else begin
                        w_abort_err = 1'b1;
                        state_d     = ASM_HEAD;
                     end
                  end
                  PKT_LAST: begin
                     w_fill      = (rem_q > 6'd3) ? 2'd3 : rem_q[1:0];
                     w_emit      = 1'b1;
                     w_emit_body = 1'b1;
                     state_d     = ASM_HEAD;
                  end
                  default: ;
               endcase
            end
            default: state_d = ASM_HEAD;
         endcase
      end

      for (int k = 0; k < SLOTS_PER_PKT; k++) begin
         if ((k < int'(w_fill)) && ((int'(ptr_q) + k) < CHANNEL)) begin
            slots_d[(int'(ptr_q) + k)*DATA_BITS +: DATA_BITS] =
               w_pkt_payload[k*DATA_BITS +: DATA_BITS];
         end
      end

      if (w_emit_body) begin
         w_emit_data = slots_d;
      end

      // A FIRST always restarts from a clean slot buffer
      if (w_start) begin
         if (w_first_ok) begin
            state_d = ASM_BODY;
            diff_d  = w_pkt_diff;
            slots_d = w_first_slots;
            rem_d   = w_pc - 6'd2;
            ptr_d   = 6'd2;
         end else begin
            w_reject_err = 1'b1;
            state_d      = ASM_HEAD;
         end
      end
   end

   // Error counter and idle flag next state; an aborting FIRST that is itself
   // unusable counts as two separate protocol errors
   always_comb begin
      link_idle_d = link_idle_q;
      if (w_pkt_valid) begin
         link_idle_d = (w_pkt_type == PKT_IDLE);
      end
      w_err_inc   = {1'b0, w_framing_err | w_abort_err} + {1'b0, w_reject_err};
      w_err_sum   = {1'b0, err_count_q} + {15'd0, w_err_inc};
      err_count_d = w_err_sum[16] ? 16'hffff : w_err_sum[15:0];
   end

   // Assembler state and output registers
   always_ff @(posedge rx_clock) begin
      if (rx_clock_rst) begin
         state_q        <= ASM_HEAD;
         diff_q         <= '0;
         slots_q        <= '0;
         rem_q          <= '0;
         ptr_q          <= '0;
         record_valid_q <= 1'b0;
         out_diff_q     <= '0;
         out_data_q     <= '0;
         keyframe_q     <= 1'b0;
         link_idle_q    <= 1'b0;
         err_count_q    <= '0;
      end else begin
         state_q        <= state_d;
         diff_q         <= diff_d;
         slots_q        <= slots_d;
         rem_q          <= rem_d;
         ptr_q          <= ptr_d;
         record_valid_q <= w_emit;
         if (w_emit) begin
            out_diff_q <= w_emit_diff;
            out_data_q <= w_emit_data;
            keyframe_q <= &w_emit_diff;
         end
         link_idle_q    <= link_idle_d;
         err_count_q    <= err_count_d;
      end
   end

   assign link.record_valid    = record_valid_q;
   assign link.diff_bitset     = out_diff_q;
   assign link.data_compressed = out_data_q;
   assign link.keyframe        = keyframe_q;
   assign link.link_idle       = link_idle_q;
   assign link.link_locked     = w_link_locked;
   assign link.err_count       = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_sample_depacketizer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sample_depacketizer
//  Description : Directed self-checking bench for sample_depacketizer with a
//                queue-based reference model compared every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sample_depacketizer;
   localparam int CH = 16;
   localparam int DB = 16;
   localparam int VB = CH * DB;

   logic clk = 1'b0;
   logic rst = 1'b1;

   sample_depacketizer_if #(.CHANNEL(CH), .DATA_BITS(DB)) link_if ();

   sample_depacketizer #(.CHANNEL(CH), .DATA_BITS(DB)) dut (
      .rx_clock     (clk),
      .rx_clock_rst (rst),
      .link         (link_if)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int rec_cnt = 0;
   bit chk_en = 1'b0;

   // Reference model state
   bit          m_hi_pend;
   logic [27:0] m_hi;
   bit          m_body;
   logic [15:0] m_diff;
   logic [15:0] m_vals[$];
   int          m_need;
   int          m_good;
   int          m_err;
   bit          m_idle;
   bit          e_rv;
   logic [15:0] e_diff;
   logic [VB-1:0] e_data;
   bit          e_key;

   task automatic check(input string name, input logic [VB-1:0] act, input logic [VB-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_emit(input logic [15:0] diff);
      e_rv   = 1'b1;
      e_diff = diff;
      e_key  = (diff == 16'hffff);
      e_data = '0;
      foreach (m_vals[i]) e_data[i*16 +: 16] = m_vals[i];
   endtask

   task automatic model_framing();
      m_err++;
      m_good = 0;
   endtask

   task automatic model_packet(input logic [5:0] t, input logic [47:0] p);
      int n;
      m_idle = (t == 6'h2a);
      n = $countones(p[15:0]);
      case (t)
         6'h11: begin
            if (m_body) m_err++;
            m_body = 1'b0;
            if (n <= 2) m_err++;
            else begin
               m_body = 1'b1;
               m_diff = p[15:0];
               m_need = n;
               m_vals.delete();
               m_vals.push_back(p[31:16]);
               m_vals.push_back(p[47:32]);
            end
         end
         6'h22: begin
            if (!m_body) m_err++;
            else if (m_need - m_vals.size() > 3) begin
               for (int k = 0; k < 3; k++) m_vals.push_back(p[k*16 +: 16]);
            end else begin
               m_err++;
               m_body = 1'b0;
            end
         end
         6'h33: begin
            if (!m_body) begin
               m_vals.delete();
               if (n >= 1) m_vals.push_back(p[31:16]);
               if (n >= 2) m_vals.push_back(p[47:32]);
               model_emit(p[15:0]);
            end else begin
               for (int k = 0; k < 3; k++)
                  if (m_vals.size() < m_need) m_vals.push_back(p[k*16 +: 16]);
               model_emit(m_diff);
               m_body = 1'b0;
            end
         end
         default: ;
      endcase
   endtask

   task automatic model_step();
      logic [27:0] w;
      logic [5:0]  t;
      w = link_if.in_data;
      e_rv = 1'b0;
      if (rst) begin
         m_hi_pend = 0; m_hi = '0; m_body = 0; m_diff = '0; m_vals.delete();
         m_need = 0; m_good = 0; m_err = 0; m_idle = 0;
         e_diff = '0; e_data = '0; e_key = 0;
         return;
      end
      if (!link_if.in_valid) return;
      if (!w[27]) begin
         if (m_hi_pend) model_framing();
         m_hi_pend = 1'b1;
         m_hi = w;
      end else if (!m_hi_pend) begin
         model_framing();
      end else begin
         m_hi_pend = 1'b0;
         t = {m_hi[26:24], w[26:24]};
         if (t inside {6'h2a, 6'h00, 6'h11, 6'h22, 6'h33}) begin
            m_good++;
            model_packet(t, {m_hi[23:0], w[23:0]});
         end else begin
            model_framing();
         end
      end
   endtask

   // Model advances on every active edge
   initial forever begin
      @(posedge clk);
      model_step();
   end

   // Every-cycle comparison against the model
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         check("record_valid", VB'(link_if.record_valid), VB'(e_rv));
         check("diff_bitset", VB'(link_if.diff_bitset), VB'(e_diff));
         check("data_compressed", link_if.data_compressed, e_data);
         check("keyframe", VB'(link_if.keyframe), VB'(e_key));
         check("link_idle", VB'(link_if.link_idle), VB'(m_idle));
         check("link_locked", VB'(link_if.link_locked), VB'(m_good >= 4));
         check("err_count", VB'(link_if.err_count), VB'((m_err > 65535) ? 65535 : m_err));
         if (link_if.record_valid === 1'b1) rec_cnt++;
      end
   end

   task automatic send(input logic [27:0] w);
      @(negedge clk);
      link_if.in_data  = w;
      link_if.in_valid = 1'b1;
   endtask

   task automatic pkt(input logic [5:0] t, input logic [47:0] p);
      send({1'b0, t[5:3], p[47:24]});
      send({1'b1, t[2:0], p[23:0]});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         link_if.in_valid = 1'b0;
      end
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rv"},     VB'(link_if.record_valid), '0);
      check({tag, "_diff"},   VB'(link_if.diff_bitset), '0);
      check({tag, "_data"},   link_if.data_compressed, '0);
      check({tag, "_key"},    VB'(link_if.keyframe), '0);
      check({tag, "_idle"},   VB'(link_if.link_idle), '0);
      check({tag, "_locked"}, VB'(link_if.link_locked), '0);
      check({tag, "_err"},    VB'(link_if.err_count), '0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [VB-1:0] exp_data;
      link_if.in_data  = '0;
      link_if.in_valid = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk_en = 1'b1;
      check_all_zero("reset");
      rst = 1'b0;

      // IDLE then NOP
      send(28'h5555555); send(28'hAAAAAAA); idle(1);
      check("idle_set", VB'(link_if.link_idle), VB'(1));
      send(28'h0101010); send(28'h8010101); idle(1);
      check("idle_clear", VB'(link_if.link_idle), VB'(0));
      check("idle_nop_err", VB'(link_if.err_count), VB'(0));
      check("idle_nop_norec", VB'(rec_cnt), VB'(0));

      // Single-packet record
      send(28'h6567812); send(28'hB340003); idle(1);
      check("single_rv", VB'(link_if.record_valid), VB'(1));
      check("single_diff", VB'(link_if.diff_bitset), VB'(16'h0003));
      check("single_data", link_if.data_compressed, VB'(32'h56781234));
      check("single_key", VB'(link_if.keyframe), VB'(0));
      idle(1);
      check("single_pulse", VB'(link_if.record_valid), VB'(0));

      // Keyframe train: value i = 16'h0100 + i
      pkt(6'h11, {16'h0101, 16'h0100, 16'hffff});
      for (int j = 0; j < 4; j++)
         pkt(6'h22, {16'(16'h0104 + 3*j), 16'(16'h0103 + 3*j), 16'(16'h0102 + 3*j)});
      pkt(6'h33, {16'h0000, 16'h010f, 16'h010e});
      idle(1);
      exp_data = '0;
      for (int i = 0; i < CH; i++) exp_data[i*16 +: 16] = 16'(16'h0100 + i);
      check("key_rv", VB'(link_if.record_valid), VB'(1));
      check("key_flag", VB'(link_if.keyframe), VB'(1));
      check("key_data", link_if.data_compressed, exp_data);
      check("key_locked", VB'(link_if.link_locked), VB'(1));

      // Errors: NEXT in HEAD, double high, lone low
      pkt(6'h22, 48'h123456789abc);
      send(28'h0111111);
      send(28'h5555555);
      send(28'hAAAAAAA);
      send(28'h8000000);
      idle(1);
      check("err_count3", VB'(link_if.err_count), VB'(3));
      check("err_unlocked", VB'(link_if.link_locked), VB'(0));
      check("err_norec", VB'(rec_cnt), VB'(2));
      pkt(6'h33, {16'h2222, 16'h1111, 16'h0003}); idle(1);
      check("err_after_rv", VB'(link_if.record_valid), VB'(1));
      check("err_after_data", link_if.data_compressed, VB'(32'h22221111));

      // Abort: fresh start from reset
      @(negedge clk); link_if.in_valid = 1'b0; rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      pkt(6'h11, {16'ha002, 16'ha001, 16'h00ff});
      pkt(6'h22, {16'ha005, 16'ha004, 16'ha003});
      pkt(6'h11, {16'h5555, 16'h6666, 16'h0001});
      idle(1);
      check("abort_err", VB'(link_if.err_count), VB'(2));
      check("abort_norec", VB'(rec_cnt), VB'(3));
      pkt(6'h33, {16'h0000, 16'hbeef, 16'h0001}); idle(1);
      check("beef_rv", VB'(link_if.record_valid), VB'(1));
      check("beef_data", link_if.data_compressed, VB'(16'hbeef));
      check("beef_diff", VB'(link_if.diff_bitset), VB'(16'h0001));

      // Reset mid-record
      pkt(6'h11, {16'h0b01, 16'h0b00, 16'hffff});
      pkt(6'h22, {16'h0b04, 16'h0b03, 16'h0b02});
      @(negedge clk); link_if.in_valid = 1'b0; rst = 1'b1;
      @(negedge clk); #1;
      check_all_zero("midrst");
      rst = 1'b0;
      pkt(6'h33, {16'h0000, 16'h7777, 16'h0001}); idle(1);
      check("post_rst_rv", VB'(link_if.record_valid), VB'(1));
      check("post_rst_data", link_if.data_compressed, VB'(16'h7777));
      pkt(6'h00, 48'h0); pkt(6'h00, 48'h0); idle(1);
      check("lock_after3", VB'(link_if.link_locked), VB'(0));
      pkt(6'h00, 48'h0); idle(1);
      check("lock_after4", VB'(link_if.link_locked), VB'(1));

      idle(3);
      check("record_total", VB'(rec_cnt), VB'(5));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
